// File: rtl/median_ctrl_pkg.sv
// median_ctrl_pkg: shared state encoding and window/timeout constants for the median window controller
package median_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, WRITE} state_t;
    localparam int WIN_SIZE    = 9;
    localparam int TIMEOUT_CYC = 32;
endpackage

// File: rtl/median_win_addr.sv
// median_win_addr: combinational address of 3x3 tap k around (x,y), clamped to the image border
module median_win_addr
    import median_ctrl_pkg::*;
#(
    parameter int W = 256,
    parameter int H = 256
) (
    input  logic [$clog2(W)-1:0] x_i,
    input  logic [$clog2(H)-1:0] y_i,
    input  logic [3:0]           k_i,
    output logic [15:0]          addr_o
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam logic [XW-1:0] XMAX = XW'(W - 1);
    localparam logic [YW-1:0] YMAX = YW'(H - 1);
    logic [3:0]    row;
    logic [3:0]    col;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    // Tap row/column select -1/0/+1 around the centre, saturating at the edges
    always_comb begin
        row    = k_i / 4'd3;
        col    = k_i % 4'd3;
        nx     = col == 4'd0 ? (x_i == '0 ? x_i : x_i - XW'(1)) :
                 col == 4'd2 ? (x_i == XMAX ? x_i : x_i + XW'(1)) : x_i;
        ny     = row == 4'd0 ? (y_i == '0 ? y_i : y_i - YW'(1)) :
                 row == 4'd2 ? (y_i == YMAX ? y_i : y_i + YW'(1)) : y_i;
        addr_o = 16'({ny, nx});
    end
endmodule

// File: rtl/median_window_ctrl.sv
// median_window_ctrl: raster-scans an image, streams each clamped 3x3 window to an external median core and writes the result back; optional WAIT timeout under MEDIAN_CTRL_TIMEOUT_EN
module median_window_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int W = 256,
    parameter int H = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RADDR,
    input  logic [7:0]  RDATA,
    output logic [7:0]  MDI,
    output logic        MDSI,
    input  logic [7:0]  MDO,
    input  logic        MDSO,
    output logic [15:0] WADDR,
    output logic [7:0]  WDATA,
    output logic        WE,
    output logic        ERR
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam logic [XW-1:0] XMAX   = XW'(W - 1);
    localparam logic [YW-1:0] YMAX   = YW'(H - 1);
    localparam logic [3:0]    LAST_K = 4'(WIN_SIZE - 1);
    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [3:0]    k_q, k_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          mdsi_q;
    logic          last_pix;
    logic [15:0]   win_addr;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
    logic [5:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    median_win_addr #(.W(W), .H(H)) u_win_addr (
        .x_i    (x_q),
        .y_i    (y_q),
        .k_i    (k_q),
        .addr_o (win_addr)
    );

    assign last_pix = (x_q == XMAX) && (y_q == YMAX);

    // Sequence the 9 tap reads, wait for the core result, write it, then step the raster position
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        wdata_d = wdata_q;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
        cnt_d   = state_q == WAIT ? cnt_q + 6'd1 : 6'd0;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (START) begin
                state_d = FETCH;
                x_d     = '0;
                y_d     = '0;
                k_d     = 4'd0;
            end
            FETCH: begin
                k_d     = k_q == LAST_K ? 4'd0 : k_q + 4'd1;
                state_d = k_q == LAST_K ? WAIT : FETCH;
            end
            WAIT: if (MDSO) begin
                wdata_d = MDO;
                state_d = WRITE;
            end
            WRITE: begin
                x_d     = x_q + XW'(1);
                y_d     = x_q == XMAX ? y_q + YW'(1) : y_q;
                state_d = last_pix ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
`ifdef MEDIAN_CTRL_TIMEOUT_EN
        if (state_q == WAIT && !MDSO && cnt_q == 6'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
`endif
    end

    // State and datapath registers; the tap strobe trails FETCH by one cycle to line up with RDATA
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= 4'd0;
            wdata_q <= 8'd0;
            mdsi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            wdata_q <= wdata_d;
            mdsi_q  <= state_q == FETCH;
        end
    end

`ifdef MEDIAN_CTRL_TIMEOUT_EN
    // WAIT cycle counter and sticky timeout flag, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= 6'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign BUSY  = state_q != IDLE;
    assign WE    = state_q == WRITE;
    assign DONE  = WE && last_pix;
    assign RADDR = state_q == FETCH ? win_addr : 16'd0;
    assign MDSI  = mdsi_q;
    assign MDI   = mdsi_q ? RDATA : 8'd0;
    assign WADDR = WE ? 16'({y_q, x_q}) : 16'd0;
    assign WDATA = WE ? wdata_q : 8'd0;
endmodule

// File: tb/tb_median_window_ctrl.sv
// tb_median_window_ctrl: randomized frames on a 4x4 image against a clamped 3x3 median model; covers MEDIAN_CTRL_TIMEOUT_EN when defined
module tb_median_window_ctrl;
    logic        CLK = 1'b0, RST = 1'b1, START = 1'b0;
    logic [7:0]  RDATA = 8'd0, MDO = 8'd0;
    logic        MDSO = 1'b0;
    logic        BUSY, DONE, MDSI, WE, ERR;
    logic [15:0] RADDR, WADDR;
    logic [7:0]  MDI, WDATA;
    int          n_chk = 0, n_fail = 0;
    int          lat = 3;
    int          cd = 0;
    int          epoch = 0, seen = 0;
    logic [7:0]  mem [16];
    logic [7:0]  win [$];
    logic [7:0]  med_r = 8'd0;
    int          fa [$];
    logic [7:0]  fd [$];
    int          wa [$];
    logic [7:0]  wd [$];
    int          done_cnt = 0, bad_we = 0;
    int          prev_raddr = 0;
    logic        prev_mdso = 1'b0;

    median_window_ctrl #(.W(4), .H(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .RADDR(RADDR), .RDATA(RDATA), .MDI(MDI), .MDSI(MDSI), .MDO(MDO), .MDSO(MDSO),
        .WADDR(WADDR), .WDATA(WDATA), .WE(WE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] med9(input logic [7:0] q[$]);
        logic [7:0] a[9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = q[i];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    function automatic int clampi(int v, int hi);
        return v < 0 ? 0 : (v > hi ? hi : v);
    endfunction

    function automatic int nb_addr(int p, int k);
        return clampi(p / 4 + k / 3 - 1, 3) * 4 + clampi(p % 4 + k % 3 - 1, 3);
    endfunction

    function automatic logic [7:0] exp_med(int p);
        logic [7:0] q[$];
        for (int k = 0; k < 9; k++) q.push_back(mem[nb_addr(p, k)]);
        return med9(q);
    endfunction

    // Source memory with 1-cycle read latency, and a median core that answers lat cycles after its 9th sample
    always @(posedge CLK) begin
        RDATA <= mem[RADDR[3:0]];
        MDSO  <= 1'b0;
        if (cd == 1) begin MDSO <= 1'b1; MDO <= med_r; end
        if (cd > 0) cd <= cd - 1;
        if (RST) win.delete();
        else if (MDSI) begin
            win.push_back(MDI);
            if (win.size() == 9) begin
                med_r <= med9(win);
                win.delete();
                if (lat > 0) cd <= lat;
            end
        end
    end

    // Observe DUT traffic: tap addresses/data (recovered from the trailing MDSI), writes, DONE pulses
    always @(negedge CLK) begin
        if (epoch != seen) begin
            fa.delete(); fd.delete(); wa.delete(); wd.delete();
            done_cnt = 0; bad_we = 0; seen = epoch;
        end
        if (MDSI) begin fa.push_back(prev_raddr); fd.push_back(MDI); end
        prev_raddr = int'(RADDR);
        if (WE) begin
            wa.push_back(int'(WADDR)); wd.push_back(WDATA);
            if (!prev_mdso) bad_we++;
        end
        if (DONE) done_cnt++;
        prev_mdso = MDSO;
    end

    task automatic randomize_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    endtask

    task automatic run_frame(input int lat_v, input bit mid, output bit to);
        lat = lat_v; epoch++;
        @(negedge CLK);
        START = 1'b1; to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            START = mid && (c % 97 == 96);
            if (DONE) begin to = 1'b0; break; end
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_chk++; if ({BUSY, DONE, WE, MDSI, ERR} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {BUSY, DONE, WE, MDSI, ERR}); end
        n_chk++; if (RADDR !== 16'd0 || WADDR !== 16'd0) begin n_fail++; $display("FAIL reset_addr: got raddr=%0d waddr=%0d want 0", RADDR, WADDR); end
        n_chk++; if (MDI !== 8'd0 || WDATA !== 8'd0) begin n_fail++; $display("FAIL reset_data: got mdi=%0d wdata=%0d want 0", MDI, WDATA); end
        RST = 1'b0; epoch++;
        repeat (10) @(negedge CLK);
        n_chk++; if (wa.size() != 0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got writes=%0d busy=%b want 0/0", wa.size(), BUSY); end
    endtask

    task automatic test_corner_00();
        int  exp_a[9];
        bit  got;
        exp_a = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
        randomize_mem(); lat = 3; epoch++;
        @(negedge CLK);
        START = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (c < 9) begin
                n_chk++; if (int'(RADDR) != exp_a[c]) begin n_fail++; $display("FAIL c00_raddr[%0d]: got %0d want %0d", c, RADDR, exp_a[c]); end
            end
            n_chk++; if (MDSI !== (c >= 1 && c <= 9)) begin n_fail++; $display("FAIL c00_mdsi[%0d]: got %b want %b", c, MDSI, c >= 1 && c <= 9); end
            if (c >= 1 && c <= 9) begin
                n_chk++; if (MDI !== mem[exp_a[c-1]]) begin n_fail++; $display("FAIL c00_mdi[%0d]: got %0d want %0d", c, MDI, mem[exp_a[c-1]]); end
            end
        end
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge CLK);
            got = DONE;
        end
        n_chk++; if (!got) begin n_fail++; $display("FAIL c00_done: got no DONE want DONE within 3000 cycles"); end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_frame();
        bit to;
        randomize_mem();
        run_frame(3, 1'b0, to);
        repeat (3) @(negedge CLK);
        n_chk++; if (to) begin n_fail++; $display("FAIL frame_timeout: got no DONE want DONE"); end
        n_chk++; if (wa.size() != 16) begin n_fail++; $display("FAIL frame_writes: got %0d want 16", wa.size()); end
        for (int i = 0; i < wa.size(); i++) begin
            n_chk++; if (wa[i] != i || wd[i] !== exp_med(i)) begin n_fail++; $display("FAIL frame_wr[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d", i, wa[i], wd[i], i, exp_med(i)); end
        end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL frame_done_cnt: got %0d want 1", done_cnt); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL frame_busy_after: got %b want 0", BUSY); end
        n_chk++; if (bad_we != 0) begin n_fail++; $display("FAIL frame_we_order: got %0d writes without MDSO want 0", bad_we); end
        n_chk++; if (fa.size() != 144) begin n_fail++; $display("FAIL frame_taps: got %0d want 144", fa.size()); end
        for (int n = 0; n < fa.size(); n++) begin
            n_chk++; if (fa[n] != nb_addr(n / 9, n % 9) || fd[n] !== mem[fa[n] % 16]) begin n_fail++; $display("FAIL frame_tap[%0d]: got addr=%0d mdi=%0d want addr=%0d mdi=%0d", n, fa[n], fd[n], nb_addr(n / 9, n % 9), mem[nb_addr(n / 9, n % 9)]); end
        end
    endtask

    task automatic test_corner_33();
        int exp_a[9];
        exp_a = '{10, 11, 11, 14, 15, 15, 14, 15, 15};
        n_chk++;
        if (fa.size() < 144) begin n_fail++; $display("FAIL c33_taps: got %0d want 144", fa.size()); end
        else for (int k = 0; k < 9; k++) if (fa[135 + k] != exp_a[k]) begin n_fail++; $display("FAIL c33_raddr[%0d]: got %0d want %0d", k, fa[135 + k], exp_a[k]); break; end
        n_chk++; if (wa.size() != 16 || wa[15] != 15) begin n_fail++; $display("FAIL c33_waddr: got %0d want 15", wa.size() == 16 ? wa[15] : -1); end
    endtask

    task automatic test_back_to_back();
        bit to;
        randomize_mem();
        run_frame(20, 1'b1, to);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_start_on_done: got busy=%b want 0", BUSY); end
        repeat (3) @(negedge CLK);
        n_chk++; if (to) begin n_fail++; $display("FAIL b2b_timeout: got no DONE want DONE"); end
        n_chk++; if (wa.size() != 16) begin n_fail++; $display("FAIL b2b_writes: got %0d want 16", wa.size()); end
        for (int i = 0; i < wa.size(); i++) begin
            n_chk++; if (wa[i] != i || wd[i] !== exp_med(i)) begin n_fail++; $display("FAIL b2b_wr[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d", i, wa[i], wd[i], i, exp_med(i)); end
        end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
        n_chk++; if (bad_we != 0) begin n_fail++; $display("FAIL b2b_we_early: got %0d writes without MDSO want 0", bad_we); end
    endtask

    task automatic test_abort();
        lat = 3; epoch++;
        @(negedge CLK);
        START = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (c == 11) RST = 1'b1;
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        n_chk++; if (wa.size() != 0 || done_cnt != 0) begin n_fail++; $display("FAIL abort_no_write: got writes=%0d done=%0d want 0/0", wa.size(), done_cnt); end
        n_chk++; if (BUSY !== 1'b0 || MDSI !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b mdsi=%b want 0/0", BUSY, MDSI); end
    endtask

    task automatic test_timeout();
        lat = 0; epoch++;
        @(negedge CLK);
        START = 1'b1;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
        for (int c = 0; c <= 41; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (c == 40) begin
                n_chk++; if (ERR !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL to_before: got err=%b busy=%b want 0/1", ERR, BUSY); end
            end
            if (c == 41) begin
                n_chk++; if (ERR !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL to_fire: got err=%b busy=%b want 1/0", ERR, BUSY); end
            end
        end
        repeat (5) @(negedge CLK);
        n_chk++; if (wa.size() != 0 || done_cnt != 0 || ERR !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got writes=%0d done=%0d err=%b want 0/0/1", wa.size(), done_cnt, ERR); end
`else
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        n_chk++; if (ERR !== 1'b0 || BUSY !== 1'b1 || wa.size() != 0) begin n_fail++; $display("FAIL wait_forever: got err=%b busy=%b writes=%0d want 0/1/0", ERR, BUSY, wa.size()); end
`endif
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_chk++; if (ERR !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL to_rst_clear: got err=%b busy=%b want 0/0", ERR, BUSY); end
        lat = 3;
    endtask

    initial begin
        randomize_mem();
        test_reset();
        test_corner_00();
        test_frame();
        test_corner_33();
        test_back_to_back();
        test_abort();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by %0t want finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
